twos_complement_serial: RTL
===========================

// Module: twos_complement_serial
// PURPOSE
//  Parametrised multi-cycle two's-complement unit: pass, negate or absolute-value of a WIDTH-bit operand.
//  Processes DIGIT bits per clock through a ripple chain of full adders with a registered inter-digit carry.
//  Sits between operand producer and ALU/display datapath; valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 2
//  DIGIT  1  bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand + mode valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  in_data    in   WIDTH  operand, two's complement
//  in_mode    in   2      00 PASS, 01 NEG, 10 ABS, 11 reserved (treated as PASS)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  result
//  out_ovf    out  1      result not representable (invert of most-negative value)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; out_valid=0, out_data=0, out_ovf=0, carry=0, digit count=0;
//    in_ready=1 once in IDLE. Reset mid-operation discards the transaction; no partial output.
//  - FSM: IDLE -(in_valid&&in_ready)-> SHIFT -(last digit)-> DONE -(out_ready)-> IDLE.
//  - Accept (IDLE, in_valid=1): latch operand into shift reg, invert = (mode==NEG) | (mode==ABS & in_data[WIDTH-1]);
//    carry <= invert; count <= 0; ovf flag <= invert & (in_data == {1'b1,{WIDTH-1{1'b0}}}).
//  - SHIFT, per cycle: low DIGIT bits of shift reg XOR {DIGIT{invert}} added to carry via DIGIT-bit ripple;
//    sum shifted into result reg from MSB side, carry-out registered; shift reg shifts right by DIGIT.
//  - N = WIDTH/DIGIT. Accept on edge k; SHIFT on edges k+1..k+N; out_valid=1 after edge k+N.
//  - DONE: out_valid=1, out_data/out_ovf held stable until out_valid&&out_ready; in_ready=0.
//    Handshake edge: out_valid<=0, state IDLE; in_ready=1 next cycle (no same-cycle re-accept).
//  - Throughput: one op per N+2 cycles with out_ready tied high.
//  - Arithmetic: result modulo 2^WIDTH; final carry-out discarded. NEG/ABS of most-negative value
//    returns the same value with out_ovf=1. NEG(0)=0, out_ovf=0. PASS never sets out_ovf.
//  - in_valid while busy is ignored (in_ready=0); producer must hold data until accepted.
//  - Mode 11 behaves exactly as PASS; no error output.
//  - N==1 (DIGIT==WIDTH): one SHIFT cycle, still registered; latency rule above applies unchanged.
// STRUCTURE
//  - Shared include twos_pkg.vh: MODE_PASS/MODE_NEG/MODE_ABS/MODE_RSVD codes, state encodings
//    ST_IDLE/ST_SHIFT/ST_DONE.
//  - Sub-module digit_adder #(DIGIT): combinational DIGIT-bit ripple built from existing full_adder
//    instances (generate loop); ports a[DIGIT-1:0], inv, cin -> y[DIGIT-1:0], cout.
//  - Top holds FSM, operand/result shift regs, carry reg, $clog2(N)-bit digit counter, handshake logic.
// TESTING
//  - WIDTH=8,DIGIT=1: NEG 0x05 -> out_data=0xFB, out_ovf=0, out_valid exactly 8 edges after accept.
//  - WIDTH=8,DIGIT=2: ABS 0x80 -> 0x80, out_ovf=1; ABS 0x9C -> 0x64; ABS 0x64 -> 0x64; latency 4.
//  - WIDTH=8,DIGIT=4: PASS 0xA7 -> 0xA7; mode 11 0xA7 -> 0xA7; NEG 0x00 -> 0x00, ovf=0.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored.
//  - Assert rst_n=0 mid-SHIFT -> out_valid=0, in_ready=1 after release; next NEG 0x01 -> 0xFF.
//  - WIDTH=16,DIGIT=16 and DIGIT=1: random 1000 ops vs (-x mod 2^16) reference model, incl. 0x8000.

Source files
------------

// File: rtl/twos_complement_serial_pkg.sv
// Shared types for the serial two's-complement unit: operation modes, FSM states, sizing helper.
package twos_complement_serial_pkg;

    // Operation codes carried on in_mode; the reserved code behaves as a pass-through.
    typedef enum logic [1:0] {
        ModePass = 2'b00,
        ModeNeg  = 2'b01,
        ModeAbs  = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Digit counter width; a single-digit operand still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the per-digit ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/twos_complement_serial_digit_adder.sv
// Combinational DIGIT-bit ripple: y = (a ^ {DIGIT{inv}}) + cin, with carry-out.
module twos_complement_serial_digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic             inv,
    input  logic             cin,
    output logic [DIGIT-1:0] y,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    // Only the carry is added, so the second adder operand is tied low.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i] ^ inv),
            .b   (1'b0),
            .cin (c[i]),
            .s   (y[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/twos_complement_serial.sv
// Multi-cycle pass / negate / absolute-value unit, DIGIT bits per clock, valid/ready on both sides.
module twos_complement_serial
    import twos_complement_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned      N        = WIDTH / DIGIT;
    localparam int unsigned      CW       = cnt_width(N);
    localparam logic [CW-1:0]    LAST     = CW'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("twos_complement_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    mode_e            mode;
    logic             accept_inv;
    logic [DIGIT-1:0] sum;
    logic             sum_cout;

    assign mode       = mode_e'(in_mode);
    // ABS only inverts negative operands; reserved mode never inverts.
    assign accept_inv = (mode == ModeNeg) | ((mode == ModeAbs) & in_data[WIDTH-1]);

    twos_complement_serial_digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .a   (shift_q[DIGIT-1:0]),
        .inv (inv_q),
        .cin (carry_q),
        .y   (sum),
        .cout(sum_cout)
    );

    // Next-state: accept in idle, one digit per cycle in shift, hold in done until drained.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        result_d = result_q;
        carry_d  = carry_q;
        inv_d    = inv_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d = in_data;
                    inv_d   = accept_inv;
                    carry_d = accept_inv;
                    cnt_d   = '0;
                    ovf_d   = accept_inv & (in_data == MOST_NEG);
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d  = shift_q >> DIGIT;
                // New digit enters at the top; after N steps digit 0 sits at the bottom.
                result_d = WIDTH'({sum, result_q} >> DIGIT);
                carry_d  = sum_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = result_q;
    assign out_ovf   = ovf_q;

endmodule
